mem_read_arbiter: RTL and testbench

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

---
 rtl/mem_read_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_read_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// mem_read_arbiter
//   Shares one read-only memory port between an instruction-read (ir) and a
//   data-read (dr) requester. Only one memory transaction is in flight at a
//   time. Each transaction runs IDLE -> ADDR -> DATA -> IDLE. When both
//   requesters ask in the same cycle, a round-robin pointer picks the winner.
//
// Ports
//   clock, reset            : clock; synchronous active-low reset
//   ir_addr_* / ir_data_*   : instruction-read address and data channels
//   dr_addr_* / dr_data_*   : data-read address and data channels
//   m_addr_* / m_data_*     : shared memory address and data channels
//   grant                   : one-hot owner (bit0 = ir, bit1 = dr), 00 idle
//   busy                    : a transaction is in flight
// ---------------------------------------------------------------------------
module mem_read_arbiter #(
    parameter int unsigned addr_width = 32,
    parameter int unsigned data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  ir_addr_valid,
    output logic                  ir_addr_ready,
    input  logic [addr_width-1:0] ir_addr,
    output logic                  ir_data_valid,
    input  logic                  ir_data_ready,
    output logic [data_width-1:0] ir_data,

    input  logic                  dr_addr_valid,
    output logic                  dr_addr_ready,
    input  logic [addr_width-1:0] dr_addr,
    output logic                  dr_data_valid,
    input  logic                  dr_data_ready,
    output logic [data_width-1:0] dr_data,

    output logic                  m_addr_valid,
    input  logic                  m_addr_ready,
    output logic [addr_width-1:0] m_addr,
    input  logic                  m_data_valid,
    output logic                  m_data_ready,
    input  logic [data_width-1:0] m_data,

    output logic [1:0]            grant,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t                state;
    logic                  last_dr;   // 1 when dr owned the last completed transaction
    logic [addr_width-1:0] addr_q;    // address captured at grant time
    logic                  win_ir;

    // ir wins when it asks alone, or when both ask and dr went last.
    assign win_ir = ir_addr_valid && (!dr_addr_valid || last_dr);

    // Transaction sequencer. The address is captured at grant so an issued
    // memory request is never withdrawn if the requester drops valid.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            grant   <= 2'b00;
            busy    <= 1'b0;
            last_dr <= 1'b1;
            addr_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ir_addr_valid || dr_addr_valid) begin
                        state  <= ADDR;
                        busy   <= 1'b1;
                        grant  <= win_ir ? 2'b01 : 2'b10;
                        addr_q <= win_ir ? ir_addr : dr_addr;
                    end
                end
                ADDR: begin
                    if (m_addr_valid && m_addr_ready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (m_data_valid && m_data_ready) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        grant   <= 2'b00;
                        last_dr <= grant[1];
                        addr_q  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Channel steering: handshakes pass straight through to the owner only
    // in the phase where they belong; everything else is held at zero.
    always_comb begin
        m_addr_valid  = 1'b0;
        m_addr        = '0;
        ir_addr_ready = 1'b0;
        dr_addr_ready = 1'b0;
        m_data_ready  = 1'b0;
        ir_data_valid = 1'b0;
        dr_data_valid = 1'b0;
        ir_data       = '0;
        dr_data       = '0;
        case (state)
            ADDR: begin
                m_addr_valid  = 1'b1;
                m_addr        = addr_q;
                ir_addr_ready = grant[0] && m_addr_ready;
                dr_addr_ready = grant[1] && m_addr_ready;
            end
            DATA: begin
                if (grant[0]) begin
                    ir_data_valid = m_data_valid;
                    ir_data       = m_data;
                    m_data_ready  = ir_data_ready;
                end else if (grant[1]) begin
                    dr_data_valid = m_data_valid;
                    dr_data       = m_data;
                    m_data_ready  = dr_data_ready;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_read_arbiter
//   Directed and random bench for mem_read_arbiter. Background processes
//   play the two requesters and the memory; a scoreboard holds the expected
//   read data per requester. Outputs are sampled on the falling edge and
//   inputs change 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_read_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          clock;
    logic          reset;
    logic [1:0]    rq_av;
    logic [AW-1:0] rq_a [2];
    logic [1:0]    rq_dr;
    wire           ir_addr_ready, dr_addr_ready, ir_data_valid, dr_data_valid;
    wire  [DW-1:0] ir_data, dr_data;
    wire           m_addr_valid, m_data_ready, busy;
    wire  [AW-1:0] m_addr;
    wire  [1:0]    grant;
    logic          m_addr_ready, m_data_valid;
    logic [DW-1:0] m_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] cmd_q0 [$];
    logic [AW-1:0] cmd_q1 [$];
    logic [DW-1:0] exp_q0 [$];
    logic [DW-1:0] exp_q1 [$];
    logic [1:0]    glog [$];

    int addr_wait = 0;
    int data_wait = 0;
    bit mem_rand  = 0;
    bit req_rand  = 0;
    int hold [2]  = '{0, 0};

    mem_read_arbiter #(.addr_width(AW), .data_width(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .ir_addr_valid (rq_av[0]),
        .ir_addr_ready (ir_addr_ready),
        .ir_addr       (rq_a[0]),
        .ir_data_valid (ir_data_valid),
        .ir_data_ready (rq_dr[0]),
        .ir_data       (ir_data),
        .dr_addr_valid (rq_av[1]),
        .dr_addr_ready (dr_addr_ready),
        .dr_addr       (rq_a[1]),
        .dr_data_valid (dr_data_valid),
        .dr_data_ready (rq_dr[1]),
        .dr_data       (dr_data),
        .m_addr_valid  (m_addr_valid),
        .m_addr_ready  (m_addr_ready),
        .m_addr        (m_addr),
        .m_data_valid  (m_data_valid),
        .m_data_ready  (m_data_ready),
        .m_data        (m_data),
        .grant         (grant),
        .busy          (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before 500us");
        $fatal(1, "watchdog expired");
    end

    // Memory contents model.
    function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_reset(input logic v);
        #2 reset = v;
    endtask

    task automatic issue(input int i, input logic [AW-1:0] a);
        if (i == 0) begin
            cmd_q0.push_back(a);
            exp_q0.push_back(mdata(a));
        end else begin
            cmd_q1.push_back(a);
            exp_q1.push_back(mdata(a));
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((cmd_q0.size() != 0 || cmd_q1.size() != 0 || exp_q0.size() != 0 ||
                exp_q1.size() != 0 || rq_av != 2'b00 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(n >= budget), 64'h0);
    endtask

    // Requester model: presents queued addresses, optionally stalls data ready.
    task automatic run_req(input int i);
        bit a_hs, dv, d_hs;
        int scnt = 0;
        forever begin
            @(negedge clock);
            a_hs = rq_av[i] && (i == 0 ? ir_addr_ready : dr_addr_ready);
            dv   = (i == 0) ? ir_data_valid : dr_data_valid;
            d_hs = dv && rq_dr[i];
            @(posedge clock);
            #1;
            if (a_hs) begin
                rq_av[i] = 1'b0;
                rq_a[i]  = '0;
            end
            if (d_hs || !reset) scnt = 0;
            else if (dv) scnt++;
            if (!rq_av[i] && (!req_rand || $urandom_range(0, 2) == 0)) begin
                if (i == 0 && cmd_q0.size() != 0) begin
                    rq_av[i] = 1'b1;
                    rq_a[i]  = cmd_q0.pop_front();
                end else if (i == 1 && cmd_q1.size() != 0) begin
                    rq_av[i] = 1'b1;
                    rq_a[i]  = cmd_q1.pop_front();
                end
            end
            rq_dr[i] = req_rand ? 1'($urandom_range(0, 1)) : (scnt >= hold[i]);
        end
    endtask

    initial begin
        rq_av = 2'b00;
        rq_dr = 2'b11;
        rq_a[0] = '0;
        rq_a[1] = '0;
    end
    initial run_req(0);
    initial run_req(1);

    // Memory model: programmable address-ready and data-valid latency.
    initial begin
        bit a_hs, d_hs, av, pend;
        logic [AW-1:0] a_now, cap;
        int acnt, dcnt, cur_aw;
        pend = 0; acnt = 0; dcnt = 0; cur_aw = 0; cap = '0;
        m_addr_ready = 1'b0;
        m_data_valid = 1'b0;
        m_data       = '0;
        forever begin
            @(negedge clock);
            a_hs  = m_addr_valid && m_addr_ready;
            d_hs  = m_data_valid && m_data_ready;
            av    = m_addr_valid;
            a_now = m_addr;
            @(posedge clock);
            #1;
            if (!reset) begin
                pend = 0;
                acnt = 0;
                m_data_valid = 1'b0;
                m_data = '0;
            end else begin
                if (d_hs) begin
                    pend = 0;
                    acnt = 0;
                    m_data_valid = 1'b0;
                    m_data = '0;
                    cur_aw = int'($urandom_range(0, 3));
                end
                if (a_hs) begin
                    pend = 1;
                    acnt = 0;
                    cap  = a_now;
                    dcnt = mem_rand ? int'($urandom_range(0, 3)) : data_wait;
                end else if (av && !m_addr_ready) begin
                    acnt++;
                end
                if (pend && !m_data_valid) begin
                    if (dcnt == 0) begin
                        m_data_valid = 1'b1;
                        m_data = mdata(cap);
                    end else begin
                        dcnt--;
                    end
                end
            end
            m_addr_ready = !pend && (acnt >= (mem_rand ? cur_aw : addr_wait));
        end
    end

    // Monitor: invariants, channel stability and scoreboard.
    initial begin
        logic pv_ma = 1'b0, pr_ma = 1'b0;
        logic [AW-1:0] pa = '0;
        logic [1:0] pdv = 2'b00, pdr = 2'b00, pg = 2'b00;
        logic [DW-1:0] pd0 = '0, pd1 = '0;
        forever begin
            @(negedge clock);
            chk("inv_grant_not_11", 64'(grant == 2'b11), 64'h0);
            chk("inv_busy_eq_grant", 64'(busy), 64'(|grant));
            if (!grant[0]) begin
                chk("ir_quiet_valid", 64'(ir_data_valid), 64'h0);
                chk("ir_quiet_data", 64'(ir_data), 64'h0);
                chk("ir_quiet_ready", 64'(ir_addr_ready), 64'h0);
            end
            if (!grant[1]) begin
                chk("dr_quiet_valid", 64'(dr_data_valid), 64'h0);
                chk("dr_quiet_data", 64'(dr_data), 64'h0);
                chk("dr_quiet_ready", 64'(dr_addr_ready), 64'h0);
            end
            if (!busy) begin
                chk("idle_m_addr_valid", 64'(m_addr_valid), 64'h0);
                chk("idle_m_data_ready", 64'(m_data_ready), 64'h0);
            end
            if (reset) begin
                if (pv_ma && !pr_ma) begin
                    chk("m_addr_valid_held", 64'(m_addr_valid), 64'h1);
                    chk("m_addr_stable", 64'(m_addr), 64'(pa));
                end
                if (pdv[0] && !pdr[0]) begin
                    chk("ir_data_valid_held", 64'(ir_data_valid), 64'h1);
                    chk("ir_data_stable", 64'(ir_data), 64'(pd0));
                end
                if (pdv[1] && !pdr[1]) begin
                    chk("dr_data_valid_held", 64'(dr_data_valid), 64'h1);
                    chk("dr_data_stable", 64'(dr_data), 64'(pd1));
                end
                if (pg != 2'b00 && grant != 2'b00)
                    chk("grant_no_switch", 64'(grant), 64'(pg));
                if (ir_data_valid && rq_dr[0]) begin
                    if (exp_q0.size() == 0) chk("sb_ir_unexpected", 64'h1, 64'h0);
                    else chk("sb_ir_data", 64'(ir_data), 64'(exp_q0.pop_front()));
                end
                if (dr_data_valid && rq_dr[1]) begin
                    if (exp_q1.size() == 0) chk("sb_dr_unexpected", 64'h1, 64'h0);
                    else chk("sb_dr_data", 64'(dr_data), 64'(exp_q1.pop_front()));
                end
            end
            if (grant != 2'b00 && pg == 2'b00) glog.push_back(grant);
            pv_ma = m_addr_valid; pr_ma = m_addr_ready; pa = m_addr;
            pdv = {dr_data_valid, ir_data_valid}; pdr = rq_dr;
            pd0 = ir_data; pd1 = dr_data; pg = grant;
        end
    end

    // Directed sequence followed by random traffic.
    initial begin
        int n;
        reset = 1'b0;
        repeat (3) tick();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_m_addr_valid", 64'(m_addr_valid), 64'h0);
        chk("rst_m_addr", 64'(m_addr), 64'h0);
        chk("rst_m_data_ready", 64'(m_data_ready), 64'h0);
        chk("rst_ir_addr_ready", 64'(ir_addr_ready), 64'h0);
        chk("rst_dr_addr_ready", 64'(dr_addr_ready), 64'h0);
        chk("rst_ir_data_valid", 64'(ir_data_valid), 64'h0);
        chk("rst_dr_data_valid", 64'(dr_data_valid), 64'h0);
        chk("rst_ir_data", 64'(ir_data), 64'h0);
        chk("rst_dr_data", 64'(dr_data), 64'h0);
        set_reset(1'b1);
        tick();

        // Single ir read, memory ready immediately.
        issue(0, 32'h100);
        tick();
        chk("t1_idle_busy", 64'(busy), 64'h0);
        tick();
        chk("t1_addr_grant", 64'(grant), 64'h1);
        chk("t1_addr_busy", 64'(busy), 64'h1);
        chk("t1_m_addr_valid", 64'(m_addr_valid), 64'h1);
        chk("t1_m_addr", 64'(m_addr), 64'h100);
        chk("t1_ir_addr_ready", 64'(ir_addr_ready), 64'h1);
        tick();
        chk("t1_data_grant", 64'(grant), 64'h1);
        chk("t1_data_m_addr_valid", 64'(m_addr_valid), 64'h0);
        chk("t1_ir_data_valid", 64'(ir_data_valid), 64'h1);
        chk("t1_ir_data", 64'(ir_data), 64'hDEADBEEF);
        chk("t1_m_data_ready", 64'(m_data_ready), 64'h1);
        tick();
        chk("t1_done_busy", 64'(busy), 64'h0);
        chk("t1_done_grant", 64'(grant), 64'h0);

        // Contention after reset: ir first, then alternation.
        set_reset(1'b0);
        tick();
        set_reset(1'b1);
        tick();
        glog.delete();
        issue(0, 32'h1000);
        issue(1, 32'h2000);
        issue(0, 32'h1004);
        issue(1, 32'h2004);
        wait_drain("t2_drain", 200);
        chk("t2_grant_count", 64'(glog.size()), 64'd4);
        chk("t2_grant0", 64'(glog[0]), 64'h1);
        chk("t2_grant1", 64'(glog[1]), 64'h2);
        chk("t2_grant2", 64'(glog[2]), 64'h1);
        chk("t2_grant3", 64'(glog[3]), 64'h2);

        // Address stall of 5 cycles.
        addr_wait = 5;
        issue(0, 32'h200);
        n = 0;
        while (!m_addr_valid && n < 20) begin tick(); n++; end
        chk("t3_reach_addr_timeout", 64'(n >= 20), 64'h0);
        for (int k = 0; k < 5; k++) begin
            chk("t3_m_addr_valid_held", 64'(m_addr_valid), 64'h1);
            chk("t3_m_addr_stable", 64'(m_addr), 64'h200);
            chk("t3_ir_addr_ready_low", 64'(ir_addr_ready), 64'h0);
            tick();
        end
        chk("t3_ir_addr_ready_high", 64'(ir_addr_ready), 64'h1);
        chk("t3_m_addr_still_valid", 64'(m_addr_valid), 64'h1);
        addr_wait = 0;
        wait_drain("t3_drain", 50);

        // dr data stall of 3 cycles with memory data waiting.
        hold[1] = 3;
        issue(1, 32'h300);
        n = 0;
        while (!dr_data_valid && n < 20) begin tick(); n++; end
        chk("t4_reach_data_timeout", 64'(n >= 20), 64'h0);
        for (int k = 0; k < 3; k++) begin
            chk("t4_m_data_ready_low", 64'(m_data_ready), 64'h0);
            chk("t4_dr_data_valid", 64'(dr_data_valid), 64'h1);
            chk("t4_dr_data", 64'(dr_data), 64'(mdata(32'h300)));
            chk("t4_grant", 64'(grant), 64'h2);
            tick();
        end
        chk("t4_m_data_ready_high", 64'(m_data_ready), 64'h1);
        chk("t4_dr_data_final", 64'(dr_data), 64'(mdata(32'h300)));
        tick();
        chk("t4_done_busy", 64'(busy), 64'h0);
        hold[1] = 0;

        // Reset while in DATA abandons the transaction.
        data_wait = 4;
        issue(0, 32'h400);
        n = 0;
        while (!(busy && !m_addr_valid) && n < 20) begin tick(); n++; end
        chk("t5_reach_data_timeout", 64'(n >= 20), 64'h0);
        set_reset(1'b0);
        tick();
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_grant", 64'(grant), 64'h0);
        chk("t5_m_addr_valid", 64'(m_addr_valid), 64'h0);
        chk("t5_m_addr", 64'(m_addr), 64'h0);
        chk("t5_m_data_ready", 64'(m_data_ready), 64'h0);
        chk("t5_ir_data_valid", 64'(ir_data_valid), 64'h0);
        chk("t5_dr_data_valid", 64'(dr_data_valid), 64'h0);
        exp_q0.delete();
        data_wait = 0;
        set_reset(1'b1);
        tick();
        glog.delete();
        issue(0, 32'h500);
        issue(1, 32'h600);
        wait_drain("t5_drain", 100);
        chk("t5_first_grant", 64'(glog[0]), 64'h1);
        chk("t5_second_grant", 64'(glog[1]), 64'h2);

        // Random traffic on both requesters with random memory latency.
        mem_rand = 1;
        req_rand = 1;
        for (int k = 0; k < 24; k++) begin
            issue(0, 32'($urandom_range(0, 16383)) << 2);
            issue(1, 32'($urandom_range(0, 16383)) << 2);
        end
        wait_drain("t6_drain", 4000);
        mem_rand = 0;
        req_rand = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
